// File: rtl/pet_io_pkg.sv
// Shared constants for the PET I/O page hub.
// Hub register offsets and the slot-count ceiling.
package pet_io_pkg;
   localparam logic [1:0] HUB_REG_MASK = 2'd0;
   localparam logic [1:0] HUB_REG_PEND = 2'd1;
   localparam logic [1:0] HUB_REG_RAW  = 2'd2;
   localparam logic [1:0] HUB_REG_ID   = 2'd3;
   localparam int         MAX_DEV      = 8;
endpackage

// File: rtl/pet_irq_latch.sv
// Per-slot interrupt latch: level follows the input,
// edge mode latches rising edges until write-1-to-clear.
module pet_irq_latch #(
   parameter bit EDGE = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_irq,
   input  logic i_w1c,
   output logic o_pend,
   output logic o_raw
);
   logic r_prev;
   logic r_pend;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev <= 1'b0;
         r_pend <= 1'b0;
      end else begin
         r_prev <= i_irq;
         // a new edge beats a clear arriving in the same clock
         if (EDGE) r_pend <= (i_irq & ~r_prev) | (r_pend & ~i_w1c);
         else      r_pend <= i_irq;
      end
   end

   assign o_pend = r_pend;
   assign o_raw  = r_prev;
endmodule

// File: rtl/pet_io_hub.sv
// PET I/O page hub: one-hot partial decode onto device slots,
// registered strobes and read mux, plus a small interrupt controller.
module pet_io_hub
   import pet_io_pkg::*;
#(
   parameter int                 NUM_DEV     = 3,
   parameter int                 ADDR_W      = 11,
   parameter int                 SEL_LSB     = 4,
   parameter logic [NUM_DEV-1:0] IRQ_EDGE    = '0,
   parameter logic [7:0]         UNMAPPED_RD = 8'hFF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce,
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   we,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   output logic                   rd_valid,
   output logic                   irq,
   output logic [NUM_DEV-1:0]     dev_strobe,
   output logic                   dev_we,
   output logic [SEL_LSB-1:0]     dev_addr,
   output logic [7:0]             dev_wdata,
   input  logic [8*NUM_DEV-1:0]   dev_rdata,
   input  logic [NUM_DEV-1:0]     dev_irq
);
   localparam int SW = ADDR_W - SEL_LSB;

   if (NUM_DEV < 1 || NUM_DEV > MAX_DEV || NUM_DEV > SW || SEL_LSB < 2) begin : g_bad
      $error("pet_io_hub: illegal NUM_DEV/ADDR_W/SEL_LSB combination");
   end

   logic [SW-1:0]      w_sel;
   logic [SW-1:0]      w_upper;
   logic [NUM_DEV-1:0] w_hit;
   logic               w_hub;
   logic [NUM_DEV-1:0] w_pend;
   logic [NUM_DEV-1:0] w_raw;
   logic [NUM_DEV-1:0] w_w1c;
   logic               w_hwr;
   logic [7:0]         w_hub_rd;
   logic [7:0]         w_rd;

   logic               r_acc;
   logic               r_hub;
   logic [1:0]         r_hreg;
   logic [NUM_DEV-1:0] r_mask;

   assign w_sel   = addr[ADDR_W-1:SEL_LSB];
   assign w_upper = w_sel >> NUM_DEV;
   assign w_hit   = (w_upper == '0) ? w_sel[NUM_DEV-1:0] : '0;
   assign w_hub   = (w_sel == '0);

   assign w_hwr = r_hub & dev_we;
   assign w_w1c = (w_hwr && r_hreg == HUB_REG_PEND) ? dev_wdata[NUM_DEV-1:0] : '0;

   for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_irq
      pet_irq_latch #(
         .EDGE (IRQ_EDGE[gi])
      ) u_latch (
         .i_clk  (clk),
         .i_rst  (reset),
         .i_irq  (dev_irq[gi]),
         .i_w1c  (w_w1c[gi]),
         .o_pend (w_pend[gi]),
         .o_raw  (w_raw[gi])
      );
   end

   always_comb begin
      w_hub_rd = 8'h00;
      unique case (r_hreg)
         HUB_REG_MASK: w_hub_rd = 8'(r_mask);
         HUB_REG_PEND: w_hub_rd = 8'(w_pend);
         HUB_REG_RAW:  w_hub_rd = 8'(w_raw);
         HUB_REG_ID:   w_hub_rd = 8'(NUM_DEV - 1);
         default:      w_hub_rd = 8'h00;
      endcase
   end

   // walk downwards so the lowest-index hit slot wins
   always_comb begin
      w_rd = r_hub ? w_hub_rd : UNMAPPED_RD;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if (dev_strobe[i]) w_rd = dev_rdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc      <= 1'b0;
         r_hub      <= 1'b0;
         r_hreg     <= 2'd0;
         dev_strobe <= '0;
         dev_we     <= 1'b0;
         dev_addr   <= '0;
         dev_wdata  <= 8'h00;
      end else begin
         r_acc      <= ce;
         r_hub      <= ce & w_hub;
         r_hreg     <= addr[1:0];
         dev_strobe <= ce ? w_hit : '0;
         dev_we     <= we;
         dev_addr   <= addr[SEL_LSB-1:0];
         dev_wdata  <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= 8'h00;
         rd_valid <= 1'b0;
         r_mask   <= '1;
         irq      <= 1'b0;
      end else begin
         rd_valid <= r_acc;
         if (r_acc) data_out <= w_rd;
         if (w_hwr && r_hreg == HUB_REG_MASK) r_mask <= dev_wdata[NUM_DEV-1:0];
         irq <= |(w_pend & r_mask);
      end
   end
endmodule
